// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector element sequencer: index type, FSM states, captured op command.
package rv32v_types_pkg;

    localparam int unsigned VLMAX = 32;
    localparam int unsigned IW    = $clog2(VLMAX) + 1;
    localparam int unsigned DW    = 32;

    typedef logic [IW-1:0] vidx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        vidx_t            vl;
        vidx_t            vstart;
        logic             vm;
        logic [VLMAX-1:0] v0_mask;
    } seq_cmd_t;

    // Requested lengths above VLMAX are limited to VLMAX so the index never wraps.
    function automatic vidx_t clamp_vl(input vidx_t v);
        return (v > vidx_t'(VLMAX)) ? vidx_t'(VLMAX) : v;
    endfunction

endpackage

// File: rtl/rv32v_seq_perf.sv
// Saturating performance counters for the element sequencer (stall cycles, committed elements).
module rv32v_seq_perf (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_stall_evt,
    input  logic        i_elem_evt,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_elem_cnt
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_elem_cnt;

    // Count events, holding at all-ones; only reset clears the counters.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_stall_cnt <= '0;
            r_elem_cnt  <= '0;
        end else begin
            if (i_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (i_elem_evt  && (r_elem_cnt  != '1)) r_elem_cnt  <= r_elem_cnt  + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_elem_cnt  = r_elem_cnt;

endmodule

// File: rtl/rv32v_elem_sequencer.sv
// Element-serial controller between vector issue and the VFU/VRF.
// Optional perf counters: define RV32V_SEQ_PERF_EN to add perf_stall_cnt / perf_elem_cnt.
module rv32v_elem_sequencer
    import rv32v_types_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  vidx_t            vl,
    input  vidx_t            vstart,
    input  logic             vm,
    input  logic [VLMAX-1:0] v0_mask,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output vidx_t            vrf_ridx,
    input  logic [DW-1:0]    vrf_rdataA,
    input  logic [DW-1:0]    vrf_rdataB,
    output logic [DW-1:0]    vfu_opA,
    output logic [DW-1:0]    vfu_opB,
    output logic             vfu_mask_bit,
    output logic             vfu_valid,
    input  logic             vfu_stall,
    input  logic [DW-1:0]    vfu_res,
    output logic             vrf_wen,
    output vidx_t            vrf_widx,
    output logic [DW-1:0]    vrf_wdata
`ifdef RV32V_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_elem_cnt
`endif
);

    seq_state_t r_state;
    vidx_t      r_idx;
    seq_cmd_t   r_cmd;

    logic  w_run;
    logic  w_active;
    logic  w_commit;
    logic  w_last;
    vidx_t w_vl_clamp;
    logic  w_unused;

    assign w_vl_clamp = clamp_vl(vl);
    assign w_run      = (r_state == RUN);
    assign w_active   = r_cmd.vm | r_cmd.v0_mask[r_idx[IW-2:0]];
    assign w_commit   = w_run & ~vfu_stall & ~flush;
    assign w_last     = (r_idx == (r_cmd.vl - vidx_t'(1)));
    // Captured start index is kept with the command but not needed after capture.
    assign w_unused   = ^r_cmd.vstart;

    // Sequencer state, element index and captured command.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cmd   <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cmd.vl      <= w_vl_clamp;
                        r_cmd.vstart  <= vstart;
                        r_cmd.vm      <= vm;
                        r_cmd.v0_mask <= v0_mask;
                        r_idx         <= vstart;
                        r_state       <= (vstart >= w_vl_clamp) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!vfu_stall) begin
                        r_idx <= r_idx + vidx_t'(1);
                        if (w_last) r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Element presentation and same-cycle commit; everything idles to zero outside RUN.
    always_comb begin
        busy         = w_run;
        done         = (r_state == DONE) & ~flush;
        vfu_valid    = w_run;
        vrf_ridx     = w_run ? r_idx : '0;
        vfu_opA      = w_run ? vrf_rdataA : '0;
        vfu_opB      = w_run ? vrf_rdataB : '0;
        vfu_mask_bit = w_run & r_cmd.v0_mask[r_idx[IW-2:0]];
        vrf_wen      = w_commit & w_active;
        vrf_widx     = w_run ? r_idx : '0;
        vrf_wdata    = w_run ? vfu_res : '0;
    end

`ifdef RV32V_SEQ_PERF_EN
    rv32v_seq_perf u_perf (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_stall_evt (w_run & vfu_stall),
        .i_elem_evt  (vrf_wen),
        .o_stall_cnt (perf_stall_cnt),
        .o_elem_cnt  (perf_elem_cnt)
    );
`endif

endmodule

// File: doc/rv32v_elem_sequencer.md
Name: rv32v_elem_sequencer

Overview:
- Element-serial controller for the vector functional unit (VFU).
- Accepts one decoded vector arithmetic op, reads operands from the VRF element by element, and drives the VFU one element per cycle.
- Holds the current element while the VFU reports a stall (multi-cycle mul/div), then commits the result to the VRF write port.
- Sits between vector decode/issue and the VFU/VRF.

Parameters:
- VLMAX, 32, max elements per op; index width IW = $clog2(VLMAX)+1.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous reset, active-high (asserted = 1; name kept per codebase convention)
- start  input  1  op issue strobe, sampled only in IDLE
- vl  input  IW  vector length for this op
- vstart  input  IW  first element index
- vm  input  1  1 = unmasked op
- v0_mask  input  VLMAX  mask register v0, one bit per element
- flush  input  1  kill current op
- busy  output  1  op in progress
- done  output  1  one-cycle completion pulse
- vrf_ridx  output  IW  element read index (combinational read, data same cycle)
- vrf_rdataA, vrf_rdataB  input  32 each  element operands from VRF
- vfu_opA, vfu_opB  output  32 each  operands to VFU
- vfu_mask_bit  output  1  raw v0 bit of current element (ADC/SBC/MERGE use)
- vfu_valid  output  1  element presented to VFU this cycle
- vfu_stall  input  1  VFU not finished with current element
- vfu_res  input  32  VFU result
- vrf_wen  output  1  element write enable
- vrf_widx  output  IW  write element index
- vrf_wdata  output  32  write data

Behaviour:
- Reset (nRST=1, async): state=IDLE; all outputs 0; idx, captured vl/vm/mask cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0.
  - On start=1: capture vl, vstart, vm, v0_mask; idx<=vstart.
  - If vstart>=vl (includes vl=0): go to DONE, no writes; else go to RUN.
- RUN: busy=1; vrf_ridx=idx; vfu_opA/B=vrf_rdataA/B; vfu_valid=1; vfu_mask_bit=mask_q[idx].
  - active = vm_q | mask_q[idx].
  - vfu_stall=1: hold idx and all VFU outputs stable; vrf_wen=0.
  - vfu_stall=0: vrf_wen=active, vrf_widx=idx, vrf_wdata=vfu_res (combinational commit); idx<=idx+1.
  - Inactive elements still take one cycle and are never written (mask-undisturbed).
  - Commit of element vl-1: next state DONE.
- Throughput: 1 element/cycle with no stalls; latency from start to done = (vl-vstart)+1 cycles plus stall cycles.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored.
- flush=1 (any state): next state IDLE, vrf_wen forced 0 that same cycle, done not pulsed.
- flush and start in the same IDLE cycle: flush wins, op not accepted.
- Reset mid-op: immediate IDLE; no partial write.
- idx never wraps: compare is idx==vl_q-1 at IW bits; vl>VLMAX is clamped to VLMAX at capture.

Optional Feature:
- Macro RV32V_SEQ_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] (RUN cycles with vfu_stall=1) and perf_elem_cnt[31:0] (committed active elements). Both are saturating, reset to 0, and not cleared by flush.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- rv32v_types_pkg gets:
  - seq_state_t enum {IDLE, RUN, DONE}
  - vidx_t (IW-bit index type)
  - struct seq_cmd_t {vl, vstart, vm, v0_mask}, captured as one register
- Sub-module rv32v_seq_perf: the two saturating counters, instantiated only under RV32V_SEQ_PERF_EN.

Test Plan:
- Basic op: vl=4, vstart=0, vm=1, vfu_stall=0, vfu_res=idx*10 -> writes idx 0..3 with data 0,10,20,30 on consecutive cycles; done on the 5th cycle after start.
- Masking: vl=4, vm=0, v0_mask=4'b0101 -> vrf_wen only at idx 0 and 2; vfu_mask_bit sequence 1,0,1,0; done after 4 RUN cycles.
- Stall: vl=2, vfu_stall high 3 cycles on idx 0 -> idx/opA held 3 cycles, single write idx0, then idx1 write; done 6 cycles after start; with PERF_EN, perf_stall_cnt=3.
- vstart boundary: vl=3, vstart=3 -> no writes, done pulses the cycle after start. vl=0 -> same.
- Flush: vl=8, flush asserted at idx 5 -> no write at idx5 or later, no done, busy=0 next cycle; new start the following cycle is accepted.
- Async reset mid-op: assert nRST during RUN at idx 2 -> outputs 0 immediately, no write; after release, IDLE with busy=0.
